// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle processor control FSM.
// Optional jump support is enabled by defining MC_JUMP_EN.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
`ifdef MC_JUMP_EN
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10
`else
        ST_BRANCH = 4'd9
`endif
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_legal(input logic [5:0] op);
        logic legal_s;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ: legal_s = 1'b1;
`ifdef MC_JUMP_EN
            OP_J:                           legal_s = 1'b1;
`endif
            default:                        legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller (master) and its datapath (slave).
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// Moore output decode: control strobes from current state (plus mem_ready in FETCH/MEM states).
// The JUMP decode exists only when MC_JUMP_EN is defined.
module mc_out_decode
    import mc_pkg::*;
(
    input  mc_state_t  i_state,
    input  logic       i_mem_ready,
    input  logic       i_op_illegal,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source,
    output logic       o_instr_done,
    output logic       o_illegal_op
);

    // Per-state control decode; anything not listed for a state stays low.
    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_B;
        o_alu_op        = ALUOP_ADD;
        o_pc_source     = PCSRC_ALU;
        o_instr_done    = 1'b0;
        o_illegal_op    = 1'b0;
        case (i_state)
            ST_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_alu_src_b  = SRCB_IMMSH;
                o_illegal_op = i_op_illegal;
            end
            ST_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            ST_MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            ST_MEMWR: begin
                o_mem_write  = 1'b1;
                o_iord       = 1'b1;
                o_instr_done = i_mem_ready;
            end
            ST_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                o_reg_dst    = 1'b1;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            ST_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PCSRC_ALUOUT;
                o_instr_done    = 1'b1;
            end
`ifdef MC_JUMP_EN
            ST_JUMP: begin
                o_pc_write   = 1'b1;
                o_pc_source  = PCSRC_JUMP;
                o_instr_done = 1'b1;
            end
`endif
            default: o_instr_done = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: state register, opcode latch and next-state logic.
// Define MC_JUMP_EN to add the JUMP state for opcode 0x02.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    mc_state_t  r_state;
    mc_state_t  w_next_state;
    logic [5:0] r_opcode;
    logic       w_op_illegal;

    assign w_op_illegal = (r_state == ST_DECODE) && !op_legal(bus.opcode);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode is captured at the end of DECODE so later IR changes cannot steer MEMADR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= 6'h00;
        end else if (r_state == ST_DECODE) begin
            r_opcode <= bus.opcode;
        end else begin
            r_opcode <= r_opcode;
        end
    end

    // Next-state logic; an unrecognised encoding falls back to FETCH.
    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_RST:    w_next_state = ST_FETCH;
            ST_FETCH:  w_next_state = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
                    w_next_state = ST_MEMADR;
                end else if (bus.opcode == OP_RTYPE) begin
                    w_next_state = ST_EXEC;
                end else if (bus.opcode == OP_BEQ) begin
                    w_next_state = ST_BRANCH;
`ifdef MC_JUMP_EN
                end else if (bus.opcode == OP_J) begin
                    w_next_state = ST_JUMP;
`endif
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEMADR: w_next_state = (r_opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  w_next_state = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  w_next_state = ST_FETCH;
            ST_MEMWR:  w_next_state = bus.mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   w_next_state = ST_RWB;
            ST_RWB:    w_next_state = ST_FETCH;
            ST_BRANCH: w_next_state = ST_FETCH;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    mc_out_decode u_out_decode (
        .i_state         (r_state),
        .i_mem_ready     (bus.mem_ready),
        .i_op_illegal    (w_op_illegal),
        .o_pc_write      (bus.PCWrite),
        .o_pc_write_cond (bus.PCWriteCond),
        .o_iord          (bus.IorD),
        .o_mem_read      (bus.MemRead),
        .o_mem_write     (bus.MemWrite),
        .o_ir_write      (bus.IRWrite),
        .o_mem_to_reg    (bus.MemtoReg),
        .o_reg_dst       (bus.RegDst),
        .o_reg_write     (bus.RegWrite),
        .o_alu_src_a     (bus.ALUSrcA),
        .o_alu_src_b     (bus.ALUSrcB),
        .o_alu_op        (bus.ALUOp),
        .o_pc_source     (bus.PCSource),
        .o_instr_done    (bus.instr_done),
        .o_illegal_op    (bus.illegal_op)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; the 0x02 expectations follow MC_JUMP_EN.
module tb_multicycle_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    multicycle_ctrl_if u_if ();

    multicycle_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
    //  ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],instr_done,illegal_op}
    logic [17:0] out_vec_s;
    assign out_vec_s = {u_if.PCWrite, u_if.PCWriteCond, u_if.IorD, u_if.MemRead,
                        u_if.MemWrite, u_if.IRWrite, u_if.MemtoReg, u_if.RegDst,
                        u_if.RegWrite, u_if.ALUSrcA, u_if.ALUSrcB, u_if.ALUOp,
                        u_if.PCSource, u_if.instr_done, u_if.illegal_op};

    localparam logic [17:0] V_RST      = 18'b0000000000_00_00_00_00;
    localparam logic [17:0] V_FETCH    = 18'b1001010000_01_00_00_00;
    localparam logic [17:0] V_FETCH_S  = 18'b0001000000_01_00_00_00;
    localparam logic [17:0] V_DEC      = 18'b0000000000_11_00_00_00;
    localparam logic [17:0] V_DEC_ILL  = 18'b0000000000_11_00_00_01;
    localparam logic [17:0] V_MEMADR   = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] V_MEMRD    = 18'b0011000000_00_00_00_00;
    localparam logic [17:0] V_MEMWB    = 18'b0000001010_00_00_00_10;
    localparam logic [17:0] V_MEMWR_S  = 18'b0010100000_00_00_00_00;
    localparam logic [17:0] V_MEMWR_D  = 18'b0010100000_00_00_00_10;
    localparam logic [17:0] V_EXEC     = 18'b0000000001_00_10_00_00;
    localparam logic [17:0] V_RWB      = 18'b0000000110_00_00_00_10;
    localparam logic [17:0] V_BRANCH   = 18'b0100000001_00_01_01_10;
    localparam logic [17:0] V_JUMP     = 18'b1000000000_00_00_10_10;

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Called just after a falling edge: apply inputs, check outputs, advance one cycle.
    task automatic cyc(input string tag, input logic [5:0] op, input logic mr,
                       input logic [17:0] exp);
        u_if.opcode    = op;
        u_if.mem_ready = mr;
        #1;
        check_eq(tag, out_vec_s, exp);
        @(negedge clk);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        u_if.opcode    = 6'h00;
        u_if.mem_ready = 1'b1;

        // Reset held: outputs stay zero across clock edges.
        @(negedge clk);
        cyc("rst_hold0", 6'h23, 1'b1, V_RST);
        cyc("rst_hold1", 6'h23, 1'b1, V_RST);
        rst_n = 1'b1;

        // lw with mem_ready tied high: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB.
        cyc("lw_rst",    6'h23, 1'b1, V_RST);
        cyc("lw_fetch",  6'h23, 1'b1, V_FETCH);
        cyc("lw_decode", 6'h23, 1'b1, V_DEC);
        cyc("lw_memadr", 6'h2B, 1'b1, V_MEMADR);
        cyc("lw_memrd",  6'h2B, 1'b1, V_MEMRD);
        cyc("lw_memwb",  6'h2B, 1'b1, V_MEMWB);

        // sw with a FETCH stall and three stalled MEMWR cycles.
        cyc("sw_fetch_stall", 6'h2B, 1'b0, V_FETCH_S);
        cyc("sw_fetch",       6'h2B, 1'b1, V_FETCH);
        cyc("sw_decode",      6'h2B, 1'b1, V_DEC);
        cyc("sw_memadr",      6'h23, 1'b1, V_MEMADR);
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("sw_memwr_stall%0d", i), 6'h23, 1'b0, V_MEMWR_S);
        end
        cyc("sw_memwr_done",  6'h23, 1'b1, V_MEMWR_D);

        // R-type.
        cyc("r_fetch",  6'h00, 1'b1, V_FETCH);
        cyc("r_decode", 6'h00, 1'b1, V_DEC);
        cyc("r_exec",   6'h00, 1'b1, V_EXEC);
        cyc("r_rwb",    6'h00, 1'b1, V_RWB);

        // beq, with opcode moved to 0x23 in the BRANCH cycle.
        cyc("beq_fetch",  6'h04, 1'b1, V_FETCH);
        cyc("beq_decode", 6'h04, 1'b1, V_DEC);
        cyc("beq_branch", 6'h23, 1'b1, V_BRANCH);

        // Unsupported opcode flags illegal in DECODE only, then back to FETCH.
        cyc("ill_fetch",  6'h3F, 1'b1, V_FETCH);
        cyc("ill_decode", 6'h3F, 1'b1, V_DEC_ILL);
        cyc("ill_refetch", 6'h3F, 1'b1, V_FETCH);

        // Jump opcode; at this point the DUT is in DECODE.
`ifdef MC_JUMP_EN
        cyc("j_decode", 6'h02, 1'b1, V_DEC);
        cyc("j_jump",   6'h02, 1'b1, V_JUMP);
`else
        cyc("j_decode", 6'h02, 1'b1, V_DEC_ILL);
`endif
        cyc("j_refetch", 6'h00, 1'b1, V_FETCH);

        // Reset asserted mid-stall in MEMRD acts without waiting for a clock.
        cyc("rr_decode", 6'h23, 1'b1, V_DEC);
        cyc("rr_memadr", 6'h23, 1'b1, V_MEMADR);
        u_if.mem_ready = 1'b0;
        #1;
        check_eq("rr_memrd_stall", out_vec_s, V_MEMRD);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rr_async_zero", out_vec_s, V_RST);
        @(negedge clk);
        cyc("rr_held", 6'h23, 1'b1, V_RST);
        rst_n = 1'b1;
        cyc("rr_rst",    6'h23, 1'b1, V_RST);
        cyc("rr_fetch",  6'h04, 1'b1, V_FETCH);
        cyc("rr_decode2", 6'h04, 1'b1, V_DEC);
        cyc("rr_branch", 6'h04, 1'b1, V_BRANCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
